// File: rtl/loopback_ring_router_pkg.sv
// Shared constants for the loopback ring router and the benches that drive it.
// Packet bit 0 is the MSB; VC_BIT and DEST_POS count from that end.
package loopback_ring_router_pkg;

  localparam int unsigned VC_BIT       = 0;
  localparam int unsigned DEST_POS_DEF = 16;
  localparam int unsigned DATA_W_DEF   = 64;
  localparam int unsigned NPORTS_DEF   = 4;
  localparam int unsigned DEPTH_DEF    = 4;

  function automatic int unsigned wrap_port(int unsigned v, int unsigned n);
    return v % n;
  endfunction

endpackage

// File: rtl/loopback_ring_router_if.sv
// Multi-port packet bus: one send/rdy pair and one DATA_W slice per port.
// master drives packets, slave accepts them.
interface loopback_ring_router_if #(
  parameter int unsigned NPORTS = 4,
  parameter int unsigned DATA_W = 64
);
  logic [NPORTS-1:0]        send;
  logic [NPORTS-1:0]        rdy;
  logic [NPORTS*DATA_W-1:0] data;

  modport master (output send, output data, input rdy);
  modport slave  (input send, input data, output rdy);
endinterface

// File: rtl/loopback_ring_router_in_fifo.sv
// Per-input circular packet buffer with wrapping pointers and an occupancy count.
// Callers only push when not full and only pop when not empty.
module loopback_ring_router_in_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/loopback_ring_router.sv
// NPORTS-way packet router: per-input FIFOs, per-output round-robin arbitration,
// injection gated by an alternating even/odd virtual-channel polarity.
module loopback_ring_router
  import loopback_ring_router_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NPORTS   = NPORTS_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned DEST_POS = DEST_POS_DEF
) (
  input  logic                   CLK,
  input  logic                   RESET,
  loopback_ring_router_if.slave  in_if,
  loopback_ring_router_if.master out_if,
  output logic                   polarity,
  output logic [15:0]            err_cnt
);
  localparam int unsigned PW = $clog2(NPORTS);
  // Packet bit i lives at vector bit DATA_W-1-i (bit 0 = MSB).
  localparam int unsigned VC_IDX   = DATA_W - 1 - VC_BIT;
  localparam int unsigned DEST_MSB = DATA_W - 1 - DEST_POS;

  logic [NPORTS-1:0]        full, empty, push, pop;
  logic [DATA_W-1:0]        head    [NPORTS];
  logic [PW-1:0]            dest    [NPORTS];
  logic [NPORTS-1:0]        req     [NPORTS];
  logic [NPORTS-1:0]        gnt_vld;
  logic [PW-1:0]            gnt_idx [NPORTS];
  logic [PW-1:0]            rr_q    [NPORTS];
  logic [PW-1:0]            cand;
  logic                     polarity_q;
  logic [15:0]              err_cnt_q, err_cnt_d;
  logic [16:0]              err_sum;
  logic [NPORTS-1:0]        out_send_q;
  logic [NPORTS*DATA_W-1:0] out_data_q;

  assign push      = in_if.send & ~full;
  assign in_if.rdy = ~full;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    loopback_ring_router_in_fifo #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .CLK  (CLK),
      .RESET(RESET),
      .push (push[p]),
      .pop  (pop[p]),
      .wdata(in_if.data[p*DATA_W +: DATA_W]),
      .head (head[p]),
      .full (full[p]),
      .empty(empty[p])
    );
    assign dest[p] = PW'(wrap_port(32'(head[p][DEST_MSB -: PW]), NPORTS));
  end

  // req[q][p]: input p's eligible head wants output q.
  always_comb begin
    for (int q = 0; q < NPORTS; q++) begin
      for (int p = 0; p < NPORTS; p++) begin
        req[q][p] = ~empty[p] & (head[p][VC_IDX] == polarity_q) & (dest[p] == PW'(q));
      end
    end
  end

  always_comb begin
    gnt_vld = '0;
    cand    = '0;
    for (int q = 0; q < NPORTS; q++) gnt_idx[q] = '0;
    for (int q = 0; q < NPORTS; q++) begin
      if (out_if.rdy[q]) begin
        for (int i = 0; i < NPORTS; i++) begin
          cand = PW'(wrap_port(32'(rr_q[q]) + 32'(i), NPORTS));
          if (!gnt_vld[q] && req[q][cand]) begin
            gnt_vld[q] = 1'b1;
            gnt_idx[q] = cand;
          end
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int q = 0; q < NPORTS; q++) begin
      if (gnt_vld[q]) pop[gnt_idx[q]] = 1'b1;
    end
  end

  always_comb begin
    err_sum = {1'b0, err_cnt_q};
    for (int p = 0; p < NPORTS; p++) begin
      err_sum = err_sum + 17'(in_if.send[p] & full[p]);
    end
    err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      polarity_q <= 1'b0;
      err_cnt_q  <= '0;
      out_send_q <= '0;
      out_data_q <= '0;
      for (int q = 0; q < NPORTS; q++) rr_q[q] <= '0;
    end else begin
      polarity_q <= ~polarity_q;
      err_cnt_q  <= err_cnt_d;
      out_send_q <= gnt_vld;
      for (int q = 0; q < NPORTS; q++) begin
        if (gnt_vld[q]) begin
          out_data_q[q*DATA_W +: DATA_W] <= head[gnt_idx[q]];
          rr_q[q] <= PW'(wrap_port(32'(gnt_idx[q]) + 32'd1, NPORTS));
        end
      end
    end
  end

  assign out_if.send = out_send_q;
  assign out_if.data = out_data_q;
  assign polarity    = polarity_q;
  assign err_cnt     = err_cnt_q;

endmodule
